inv_share_arbiter: RTL

INV_SHARE_ARBITER -- requirements
Module: inv_share_arbiter

---
 rtl/inv_share_arbiter.sv | 90 +++++++++
 1 files changed

// File: rtl/inv_share_arbiter.sv
// inv_share_arbiter: round-robin arbiter sharing one reciprocal unit among NUM_REQ requesters.
// Define INV_SHARE_ARBITER_ZERO_BYPASS_EN to answer zero operands with all-ones without using the unit.
module inv_share_arbiter #(
    parameter int DATA_WIDTH = 24,
    parameter int NUM_REQ    = 4,
    localparam int ID_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          resp_valid,
    output logic [DATA_WIDTH-1:0]         resp_data,
    output logic [ID_W-1:0]               resp_id,
    input  logic                          resp_ready,
    input  logic                          inv_ready,
    output logic [DATA_WIDTH-1:0]         inv_a,
    output logic                          inv_a_dv,
    input  logic [DATA_WIDTH-1:0]         inv_a_inv,
    input  logic                          inv_a_inv_dv,
    output logic                          busy
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
    state_t state, state_nxt;
    logic [ID_W-1:0] rr_ptr, gnt_id, cand;
    logic [DATA_WIDTH-1:0] gnt_data, op_q;
    logic gnt_found, grant, bypass;
    int j;
    // First valid requester at or above rr_ptr, wrapping around.
    always_comb begin
        gnt_id    = '0;
        gnt_data  = '0;
        gnt_found = 1'b0;
        cand      = '0;
        j         = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            j    = int'(rr_ptr) + i;
            j    = (j >= NUM_REQ) ? j - NUM_REQ : j;
            cand = ID_W'(j);
            if (!gnt_found && req_valid[cand]) begin
                gnt_found = 1'b1;
                gnt_id    = cand;
                gnt_data  = req_data[j*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end
    assign grant = !rst && state == IDLE && inv_ready && gnt_found;
`ifdef INV_SHARE_ARBITER_ZERO_BYPASS_EN
    assign bypass = gnt_data == '0;
`else
    assign bypass = 1'b0;
`endif
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end
    always_comb begin
        state_nxt = state == IDLE  ? (grant ? (bypass ? RESP : ISSUE) : IDLE) :
                    state == ISSUE ? WAIT :
                    state == WAIT  ? (inv_a_inv_dv ? RESP : WAIT) :
                                     (resp_ready ? IDLE : RESP);
    end
    always_comb begin
        req_ready  = grant ? NUM_REQ'(1) << gnt_id : '0;
        inv_a_dv   = state == ISSUE;
        inv_a      = inv_a_dv ? op_q : '0;
        resp_valid = state == RESP;
        busy       = state != IDLE;
    end
    // Result strobes outside WAIT are stale or spurious and are dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr    <= '0;
            op_q      <= '0;
            resp_id   <= '0;
            resp_data <= '0;
        end else if (grant) begin
            rr_ptr  <= (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;
            op_q    <= gnt_data;
            resp_id <= gnt_id;
            if (bypass)
                resp_data <= '1;
        end else if (state == WAIT && inv_a_inv_dv) begin
            resp_data <= inv_a_inv;
        end
    end
endmodule
